// File: rtl/ball_packet_rx.sv
// I2C write-only responder that collects a fixed-length ball-state frame and
// commits it to the rx_* outputs only when a clean STOP ends a complete frame.
`timescale 1ns/1ps
module ball_packet_rx #(
   parameter logic [6:0]  SLV_ADDR  = 7'h12,
   parameter int unsigned NUM_BYTES = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SCL,
   inout  wire        SDA,
   output logic [9:0] rx_ball_y,
   output logic [7:0] rx_ball_vy,
   output logic [1:0] rx_gravity,
   output logic       rx_collision,
   output logic       frame_valid,
   output logic       frame_err,
   output logic       is_receiving,
   output logic [7:0] rx_led
);

   localparam int unsigned IDX_W = $clog2(NUM_BYTES + 1);
   localparam int unsigned BIT_W = 3;
   localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(NUM_BYTES);
   localparam logic [7:0]       ADDR_WR  = {SLV_ADDR, 1'b0};

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      WAIT_STOP
   } state_e;

   state_e           state_q, state_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [6:0]       shift_q, shift_d;
   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic             ovf_q, ovf_d;
   logic             sda_low_q, sda_low_d;
   logic             is_rx_q, is_rx_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   logic scl_meta_q, scl_sync_q, scl_dly_q;
   logic sda_meta_q, sda_sync_q, sda_dly_q;

   logic [7:0] sh_y_lo_q;
   logic [1:0] sh_y_hi_q;
   logic [7:0] sh_vy_q;
   logic [1:0] sh_grav_q;
   logic       sh_coll_q;

   logic [9:0] rx_ball_y_q;
   logic [7:0] rx_ball_vy_q;
   logic [1:0] rx_gravity_q;
   logic       rx_collision_q;
   logic [7:0] rx_led_q;

   logic       start_c, stop_c, scl_rise_c, scl_fall_c;
   logic [7:0] byte_c;
   logic       shadow_we_c, led_we_c, commit_c;

   // Bus conditions are judged only on synchronized samples.
   assign start_c    = scl_sync_q & scl_dly_q & sda_dly_q & ~sda_sync_q;
   assign stop_c     = scl_sync_q & scl_dly_q & ~sda_dly_q & sda_sync_q;
   assign scl_rise_c = scl_sync_q & ~scl_dly_q;
   assign scl_fall_c = ~scl_sync_q & scl_dly_q;
   assign byte_c     = {shift_q, sda_sync_q};

   assign SDA = sda_low_q ? 1'b0 : 1'bz;

   assign rx_ball_y    = rx_ball_y_q;
   assign rx_ball_vy   = rx_ball_vy_q;
   assign rx_gravity   = rx_gravity_q;
   assign rx_collision = rx_collision_q;
   assign frame_valid  = valid_q;
   assign frame_err    = err_q;
   assign is_receiving = is_rx_q;
   assign rx_led       = rx_led_q;

   // Synchronizers idle high so reset release never looks like a START.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_dly_q  <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_dly_q  <= 1'b1;
      end else begin
         scl_meta_q <= SCL;
         scl_sync_q <= scl_meta_q;
         scl_dly_q  <= scl_sync_q;
         sda_meta_q <= SDA;
         sda_sync_q <= sda_meta_q;
         sda_dly_q  <= sda_sync_q;
      end
   end

   // STOP and START take priority over the per-state protocol handling.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_idx_d  = byte_idx_q;
      ovf_d       = ovf_q;
      sda_low_d   = sda_low_q;
      is_rx_d     = is_rx_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      shadow_we_c = 1'b0;
      led_we_c    = 1'b0;
      commit_c    = 1'b0;

      if (stop_c) begin
         if (state_q != IDLE) begin
            if (ovf_q || ((byte_idx_q != '0) && (byte_idx_q != FULL_IDX))) begin
               err_d = 1'b1;
            end else if (byte_idx_q == FULL_IDX) begin
               valid_d  = 1'b1;
               commit_c = 1'b1;
            end
         end
         state_d    = IDLE;
         bit_cnt_d  = '0;
         byte_idx_d = '0;
         ovf_d      = 1'b0;
         sda_low_d  = 1'b0;
         is_rx_d    = 1'b0;
      end else if (start_c) begin
         err_d      = (state_q != IDLE) && (byte_idx_q != '0);
         state_d    = ADDR;
         bit_cnt_d  = '0;
         byte_idx_d = '0;
         ovf_d      = 1'b0;
         sda_low_d  = 1'b0;
         is_rx_d    = 1'b0;
      end else begin
         case (state_q)
            ADDR: begin
               if (scl_rise_c) begin
                  shift_d   = byte_c[6:0];
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q == BIT_W'(7)) begin
                     if (byte_c == ADDR_WR) begin
                        state_d = ADDR_ACK;
                        is_rx_d = 1'b1;
                     end else begin
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end
            // First SCL fall after the byte starts the ACK, the next ends it.
            ADDR_ACK, DATA_ACK: begin
               if (scl_fall_c) begin
                  if (!sda_low_q) begin
                     sda_low_d = 1'b1;
                  end else begin
                     sda_low_d = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = DATA;
                  end
               end
            end
            DATA: begin
               if (scl_rise_c) begin
                  shift_d   = byte_c[6:0];
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  if (bit_cnt_q == BIT_W'(7)) begin
                     led_we_c = 1'b1;
                     if (byte_idx_q < FULL_IDX) begin
                        shadow_we_c = 1'b1;
                        byte_idx_d  = byte_idx_q + IDX_W'(1);
                        state_d     = DATA_ACK;
                     end else begin
                        ovf_d   = 1'b1;
                        state_d = WAIT_STOP;
                     end
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         byte_idx_q <= '0;
         ovf_q      <= 1'b0;
         sda_low_q  <= 1'b0;
         is_rx_q    <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         ovf_q      <= ovf_d;
         sda_low_q  <= sda_low_d;
         is_rx_q    <= is_rx_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   // Shadow keeps only the bits each frame byte contributes to the outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_y_lo_q <= '0;
         sh_y_hi_q <= '0;
         sh_vy_q   <= '0;
         sh_grav_q <= '0;
         sh_coll_q <= 1'b0;
      end else if (shadow_we_c) begin
         if (byte_idx_q == IDX_W'(0)) sh_y_lo_q <= byte_c;
         if (byte_idx_q == IDX_W'(1)) sh_y_hi_q <= byte_c[1:0];
         if (byte_idx_q == IDX_W'(2)) sh_vy_q   <= byte_c;
         if (byte_idx_q == IDX_W'(3)) sh_grav_q <= byte_c[1:0];
         if (byte_idx_q == IDX_W'(4)) sh_coll_q <= byte_c[0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_ball_y_q    <= '0;
         rx_ball_vy_q   <= '0;
         rx_gravity_q   <= '0;
         rx_collision_q <= 1'b0;
         rx_led_q       <= '0;
      end else begin
         if (led_we_c) rx_led_q <= byte_c;
         if (commit_c) begin
            rx_ball_y_q    <= {sh_y_hi_q, sh_y_lo_q};
            rx_ball_vy_q   <= sh_vy_q;
            rx_gravity_q   <= sh_grav_q;
            rx_collision_q <= sh_coll_q;
         end
      end
   end

endmodule

// File: doc/ball_packet_rx.md
BALL_PACKET_RX -- requirements
Module: ball_packet_rx

Interface
REQ-001 Parameter SLV_ADDR, default 7'h12: 7-bit I2C address this responder acknowledges.
REQ-002 Parameter NUM_BYTES, default 5: data bytes per complete ball frame.
REQ-003 clk  input  1  system clock; SCL/SDA are sampled in this domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 SCL  input  1  I2C clock from the remote initiator.
REQ-006 SDA  inout  1  I2C data, open-drain: the block drives only 1'b0 or 1'bz.
REQ-007 rx_ball_y  output  10  received ball y = {byte1[1:0], byte0}.
REQ-008 rx_ball_vy  output  8  received ball vertical velocity = byte2.
REQ-009 rx_gravity  output  2  received gravity counter = byte3[1:0].
REQ-010 rx_collision  output  1  received collision flag = byte4[0].
REQ-011 frame_valid  output  1  one-cycle pulse: a complete frame was committed.
REQ-012 frame_err  output  1  one-cycle pulse: a frame was aborted.
REQ-013 is_receiving  output  1  high from an address-matched START until frame end.
REQ-014 rx_led  output  8  last data byte shifted in (debug).

Function
REQ-015 SCL and SDA are each passed through a 2-flop synchronizer; all edge and condition detection uses the synchronized values and their one-cycle-delayed copies.
REQ-016 START = synchronized SDA falls while SCL is high; STOP = synchronized SDA rises while SCL is high; data bits are sampled on the SCL rising edge.
REQ-017 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
REQ-018 IDLE -> ADDR on START; bit counter and byte index clear.
REQ-019 ADDR: shift 8 bits MSB-first; after the 8th rise, match {SLV_ADDR, 1'b0} -> ADDR_ACK, else -> WAIT_STOP with SDA released (NACK).
REQ-020 Read requests (R/W=1) to SLV_ADDR are NACKed and go to WAIT_STOP; no frame_err.
REQ-021 ACK: SDA is driven low from the SCL fall after the 8th bit until the next SCL fall, then released; ADDR_ACK -> DATA, DATA_ACK -> DATA.
REQ-022 DATA: shift 8 bits into a shadow byte register at the current byte index and into rx_led; byte index < NUM_BYTES -> ACK, else NACK and -> WAIT_STOP with an overflow flag set.
REQ-023 Shadow registers commit to the rx_* outputs only on STOP with exactly NUM_BYTES bytes ACKed; frame_valid pulses in the cycle after STOP detection.
REQ-024 STOP with 0 < bytes < NUM_BYTES, or after overflow: no commit, frame_err pulses once, -> IDLE.
REQ-025 STOP right after the address phase (0 data bytes): no commit, no pulse.
REQ-026 Repeated START in any state discards the shadow bytes, pulses frame_err if at least one byte was ACKed, and goes to ADDR.
REQ-027 STOP detected in any state returns to IDLE and releases SDA in the same cycle.
REQ-028 rx_* outputs hold their last committed values indefinitely; frame_valid and frame_err are never high together.

Reset
REQ-029 While reset = 0: state IDLE, SDA = 1'bz, all rx_* = 0, rx_led = 0, frame_valid = frame_err = is_receiving = 0, synchronizer flops = 1.
REQ-030 Reset asserted mid-frame aborts the frame immediately and releases SDA asynchronously; after release, the block waits for a fresh START.

Verification
REQ-031 Write 0x24, bytes 0x3C,0x02,0xF8,0x03,0x01, STOP -> six ACKs; frame_valid 1 cycle; rx_ball_y=10'h23C, rx_ball_vy=8'hF8, rx_gravity=2'b11, rx_collision=1.
REQ-032 Address byte 0x26 followed by data -> all bits NACKed (SDA never driven); no pulses; outputs unchanged.
REQ-033 0x24, bytes 0x10,0x00, STOP -> two data ACKs; frame_err 1 cycle; outputs keep their previous frame values.
REQ-034 0x24 with 6 data bytes -> sixth byte NACKed; STOP -> frame_err, no commit.
REQ-035 Repeated START after 3 bytes, then a valid 5-byte frame -> one frame_err then one frame_valid; outputs equal the second frame.
REQ-036 reset = 0 during the ACK of byte 2 -> SDA released within the reset cycle, outputs 0; a following valid frame is received correctly.
